rr_arbiter8: RTL and testbench
==============================

Name: rr_arbiter8

Overview:
- Eight-requester round-robin arbiter with a held grant and a release handshake.
- Produces a registered one-hot grant vector that feeds directly into the team's 8-to-3 one-hot encoder, which turns it into a 3-bit index.
- Guarantees the encoder never sees more than one bit set.
- Used wherever eight masters share one resource (bus, buffer port).

Parameters:
N_REQ, 8, number of requesters; fixed at 8 in this revision so the grant width matches the encoder input.
PTR_W, 3, width of the round-robin pointer; equals log2(N_REQ).

Ports:
clk  in  1  single clock; all state updates on rising edge.
rst_n  in  1  asynchronous, active-low reset; assertion clears all state immediately, deassertion synchronous to clk.
req  in  8  request vector; bit i high = requester i wants the resource; may have any number of bits set.
rel  in  1  release pulse from current grantee; sampled only in GRANT state.
gnt  out  8  registered one-hot grant; all-zero when idle.
gnt_valid  out  1  high exactly when gnt is non-zero.

Behaviour:
Reset (rst_n low, async):
- gnt=8'h00, gnt_valid=0, state=IDLE.
- ptr=0, so bit 0 has highest priority after reset.

States: IDLE, GRANT.

Pick rule:
- Lowest-index set bit of the masked request vector, searched circularly starting at ptr (ptr, ptr+1, ... wrapping 7->0).
- Result is one-hot or zero.

IDLE:
- If req != 0: pick from req; gnt <= pick; state <= GRANT; ptr <= picked index + 1 (mod 8, 7 wraps to 0).
- Else stay in IDLE with gnt=0.
- Latency: req sampled high in cycle n gives gnt visible in cycle n+1.

GRANT:
- Grant is held while rel=0 and req[granted]=1; the grant never changes on its own.
- Release occurs when rel=1 OR req[granted]=0 (a dropped request releases without rel).
- On release, let other = req & ~gnt:
  - If other != 0: pick from other; gnt switches directly to the new one-hot value next cycle, with no idle bubble; ptr updated as in IDLE.
  - Else: gnt <= 0, state <= IDLE.
- A grantee that re-requests while alone is re-granted after one idle cycle (IDLE -> GRANT); it cannot hog the resource back-to-back while others wait.

Boundary conditions:
- All 8 requesting: grants rotate 0,1,...,7,0 with one grant per release.
- Pointer wrap: grantee 7 releases; next search starts at bit 0.
- rel asserted in IDLE: ignored.
- rel and req change in the same cycle: evaluated together per the release rule.
- Reset mid-grant: gnt clears asynchronously; ptr returns to 0.

Invariants:
- gnt is always zero or one-hot (verify with an assertion).
- gnt_valid == |gnt.

Optional Feature:
Macro: RR_ARB_LOCK_EN
- Defined: adds input port lock (1 bit), placed after rel.
  - While state=GRANT and lock=1, rel is ignored and the grant is held (burst lock).
  - A dropped req[granted] still releases, so a dead master cannot deadlock the arbiter.
  - lock is ignored in IDLE.
- Undefined: no lock port; behaviour exactly as above.

Decomposition:
Shared package arb_pkg holds:
- N_REQ=8 and PTR_W=3.
- State enum type (IDLE, GRANT).
- The function computing index+1 mod N_REQ.

Sub-module rr_pick8 (combinational):
- Inputs: 8-bit vector, 3-bit ptr.
- Outputs: 8-bit one-hot pick and 3-bit picked index.
- Implementation: rotate right by ptr, take lowest set bit, rotate back.
- Instantiated once; the top holds the FSM, ptr and output registers.

Test Plan:
1. Reset, then req=8'h01 -> next cycle gnt=8'h01, gnt_valid=1; ptr=1; pulse rel with req=0 -> gnt=8'h00 next cycle.
2. req=8'hFF held, rel pulsed every 2 cycles -> gnt sequence 01,02,04,08,10,20,40,80,01 with no zero cycles between grants.
3. Grantee 3 (gnt=8'h08) drops req[3] with rel=0 while req[5]=1 -> next cycle gnt=8'h20.
4. Wrap: after a grant to bit 7, req=8'h81 and rel=1 -> gnt=8'h01, not 8'h80.
5. Alone: only req[2] high, rel pulse -> one cycle gnt=0, then gnt=8'h04 again.
6. rst_n low mid-grant (gnt=8'h10) -> gnt=0 without waiting for a clock edge; after release, req=8'h30 -> gnt=8'h10 (ptr back to 0).
   With RR_ARB_LOCK_EN: lock=1 and rel=1 -> gnt unchanged.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: sizes, FSM state,
// register bundle and the circular pointer increment.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int PTR_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Everything the arbiter remembers between cycles.
  typedef struct packed {
    logic [N_REQ-1:0] gnt;
    logic [PTR_W-1:0] ptr;
    arb_state_e       st;
  } arb_regs_t;

  // index + 1 mod N_REQ; N_REQ is a power of two so natural wrap does it.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return p + PTR_W'(1);
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Circular priority picker: first set bit of vec searching from ptr upward,
// wrapping 7->0. Pure combinational; output is one-hot or zero.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] vec,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] pick,
  output logic [PTR_W-1:0] idx
);

  logic [2*N_REQ-1:0] dbl_r;
  logic [2*N_REQ-1:0] dbl_b;
  logic [N_REQ-1:0]   rot;
  logic [N_REQ-1:0]   lsb;
  logic [PTR_W-1:0]   ridx;

  // Rotate so ptr lands on bit 0, isolate lowest set bit, rotate back.
  always_comb begin
    dbl_r = {vec, vec} >> ptr;
    rot   = dbl_r[N_REQ-1:0];
    lsb   = rot & (~rot + N_REQ'(1));
    dbl_b = {lsb, lsb} << ptr;
    pick  = dbl_b[2*N_REQ-1:N_REQ];
    ridx  = '0;
    for (int i = 0; i < N_REQ; i++)
      if (lsb[i]) ridx = PTR_W'(i);
    idx   = ridx + ptr;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with held grant and release handshake.
// gnt is registered and always zero or one-hot so it can drive the 8-to-3
// one-hot encoder directly.
// Optional: define RR_ARB_LOCK_EN to add a 'lock' input that blocks rel
// while granted (a dropped request still releases).
module rr_arbiter8
  import arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             rel,
`ifdef RR_ARB_LOCK_EN
  input  logic             lock,
`endif
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid
);

  arb_regs_t        r_q, r_d;
  logic [N_REQ-1:0] pick_vec;
  logic [N_REQ-1:0] pick;
  logic [PTR_W-1:0] pick_idx;
  logic             rel_eff;
  logic             rls;

`ifdef RR_ARB_LOCK_EN
  assign rel_eff = rel & ~lock;
`else
  assign rel_eff = rel;
`endif

  // While granted, the current holder is excluded so it cannot be re-picked
  // back-to-back; in IDLE every request competes.
  assign pick_vec = (r_q.st == GRANT) ? (req & ~r_q.gnt) : req;

  rr_pick8 u_pick (
    .vec  (pick_vec),
    .ptr  (r_q.ptr),
    .pick (pick),
    .idx  (pick_idx)
  );

  // Next-state: grant from IDLE, or hand over / drop on release in GRANT.
  always_comb begin
    r_d = r_q;
    rls = rel_eff || ((req & r_q.gnt) == '0);
    unique case (r_q.st)
      IDLE: begin
        if (req != '0) begin
          r_d.gnt = pick;
          r_d.ptr = ptr_inc(pick_idx);
          r_d.st  = GRANT;
        end
      end
      GRANT: begin
        if (rls) begin
          if (pick_vec != '0) begin
            r_d.gnt = pick;
            r_d.ptr = ptr_inc(pick_idx);
          end else begin
            r_d.gnt = '0;
            r_d.st  = IDLE;
          end
        end
      end
      default: r_d.st = IDLE;
    endcase
  end

  // State register; reset clears grant and pointer immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= '{gnt: '0, ptr: '0, st: IDLE};
    else        r_q <= r_d;
  end

  assign gnt       = r_q.gnt;
  assign gnt_valid = |r_q.gnt;

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] req = 8'h00;
  logic       rel = 1'b0;
`ifdef RR_ARB_LOCK_EN
  logic       lock = 1'b0;
`endif
  logic [7:0] gnt;
  logic       gnt_valid;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rr_arbiter8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .rel       (rel),
`ifdef RR_ARB_LOCK_EN
    .lock      (lock),
`endif
    .gnt       (gnt),
    .gnt_valid (gnt_valid)
  );

  // Model: holder index (-1 = nobody) and search start.
  int m_idx = -1;
  int m_ptr = 0;

  function automatic logic [7:0] m_gnt(input int idx);
    logic [7:0] v;
    v = 8'h00;
    if (idx >= 0) v[idx] = 1'b1;
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic [7:0] cand;
    bit         go;
    bit         rl;
    int         found;
    if (!rst_n) begin
      m_idx = -1;
      m_ptr = 0;
    end else begin
      rl = rel;
`ifdef RR_ARB_LOCK_EN
      rl = rel && !lock;
`endif
      cand = req;
      go   = 1'b1;
      if (m_idx >= 0) begin
        go = rl || !req[m_idx];
        cand[m_idx] = 1'b0;
      end
      if (go) begin
        found = -1;
        for (int k = 0; k < 8; k++)
          if (found < 0 && cand[(m_ptr + k) % 8]) found = (m_ptr + k) % 8;
        m_idx = found;
        if (found >= 0) m_ptr = (found + 1) % 8;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin : cmp
    logic [7:0] e;
    e = m_gnt(m_idx);
    tests++;
    if (gnt !== e || gnt_valid !== (e != 8'h00)) begin
      fails++;
      $display("FAIL cycle_cmp t=%0t gnt=%h vld=%b expected gnt=%h vld=%b",
               $time, gnt, gnt_valid, e, (e != 8'h00));
    end
  end

  task automatic chk(input string nm, input logic [7:0] e);
    tests++;
    if (gnt !== e || gnt_valid !== (e != 8'h00)) begin
      fails++;
      $display("FAIL %s gnt=%h vld=%b expected gnt=%h vld=%b",
               nm, gnt, gnt_valid, e, (e != 8'h00));
    end
  endtask

  // Apply inputs, let one rising edge sample them, look just after it.
  task automatic drv(input logic [7:0] r, input logic rl);
    req = r;
    rel = rl;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req   = 8'h00;
    rel   = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset", 8'h00);

    // basic grant / release
    drv(8'h01, 1'b0); chk("t1_grant", 8'h01);
    drv(8'h00, 1'b1); chk("t1_release", 8'h00);

    // rel in IDLE is ignored
    drv(8'h00, 1'b1); chk("idle_rel", 8'h00);
    drv(8'h02, 1'b1); chk("idle_rel_grant", 8'h02);
    drv(8'h00, 1'b0); chk("drop_to_idle", 8'h00);

    // all requesting, full rotation
    do_reset();
    drv(8'hFF, 1'b0); chk("rot_first", 8'h01);
    for (int i = 1; i <= 8; i++) begin
      logic [7:0] one;
      one = 8'h01;
      drv(8'hFF, 1'b0); chk("rot_hold", one << ((i - 1) % 8));
      drv(8'hFF, 1'b1); chk("rot_next", one << (i % 8));
    end

    // dropped request releases without rel
    do_reset();
    drv(8'h08, 1'b0); chk("t3_grant", 8'h08);
    drv(8'h28, 1'b0); chk("t3_hold", 8'h08);
    drv(8'h20, 1'b0); chk("t3_drop", 8'h20);

    // pointer wrap after grantee 7
    do_reset();
    drv(8'h80, 1'b0); chk("t4_grant7", 8'h80);
    drv(8'h81, 1'b1); chk("t4_wrap", 8'h01);
    do_reset();
    drv(8'h80, 1'b0); chk("t4b_grant7", 8'h80);
    drv(8'hC1, 1'b1); chk("t4b_wrap", 8'h01);

    // lone re-requester gets one idle cycle
    do_reset();
    drv(8'h04, 1'b0); chk("t5_grant", 8'h04);
    drv(8'h04, 1'b1); chk("t5_bubble", 8'h00);
    drv(8'h04, 1'b0); chk("t5_regrant", 8'h04);
    // rel and req change together: ptr=3, others 0 and 3 -> 3
    drv(8'h09, 1'b1); chk("same_cycle", 8'h08);

    // async reset mid-grant, pointer back to 0
    do_reset();
    drv(8'h10, 1'b0); chk("t6_grant", 8'h10);
    #2 rst_n = 1'b0;
    #1 chk("t6_async_clear", 8'h00);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drv(8'h30, 1'b0); chk("t6_ptr0", 8'h10);

`ifdef RR_ARB_LOCK_EN
    do_reset();
    drv(8'h03, 1'b0); chk("lock_grant", 8'h01);
    lock = 1'b1;
    drv(8'h03, 1'b1); chk("lock_hold", 8'h01);
    drv(8'h02, 1'b1); chk("lock_drop", 8'h02);
    lock = 1'b0;
`endif

    // randomized traffic, model compared every cycle
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      req   = 8'($urandom & $urandom);
      rel   = ($urandom_range(0, 2) == 0);
`ifdef RR_ARB_LOCK_EN
      lock  = ($urandom_range(0, 3) == 0);
`endif
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    drv(8'h00, 1'b0);
    drv(8'h00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
